mem_responder: RTL

- Memory-side responder for the core's valid/ready memory interface; serves fetcher and LSU read/write requests from NUM_CHANNELS requesters against an on-chip word array.
- Round-robin arbitration across channels, fixed response latency, one-cycle ready pulse per request.
- Sits between one or more miniGPU cores and the backing data/program store.
- Also provides the testbench preload path.

---
 rtl/mem_responder_pkg.sv | 21 ++
 rtl/mem_responder_if.sv | 32 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/mem_responder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM state, operation kind and
// channel-index sizing.
package mem_responder_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  localparam int unsigned CNT_BITS = 4;

  function automatic int unsigned chan_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Per-channel valid/ready memory bus plus the preload path and debug status.
interface mem_responder_if #(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 16
);
  logic [NUM_CHANNELS-1:0]           ch_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_read_address;
  logic [NUM_CHANNELS-1:0]           ch_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_read_data;
  logic [NUM_CHANNELS-1:0]           ch_write_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_write_data;
  logic [NUM_CHANNELS-1:0]           ch_write_ready;
  logic                              init_write_en;
  logic [ADDR_BITS-1:0]              init_address;
  logic [DATA_BITS-1:0]              init_data;
  logic                              busy;
  logic [7:0]                        grant_channel;

  modport master (
    output ch_read_valid, ch_read_address, ch_write_valid, ch_write_address,
           ch_write_data, init_write_en, init_address, init_data,
    input  ch_read_ready, ch_read_data, ch_write_ready, busy, grant_channel
  );

  modport slave (
    input  ch_read_valid, ch_read_address, ch_write_valid, ch_write_address,
           ch_write_data, init_write_en, init_address, init_data,
    output ch_read_ready, ch_read_data, ch_write_ready, busy, grant_channel
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, with wrap-around.
module rr_arbiter
  import mem_responder_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2
) (
  input  logic [NUM_CHANNELS-1:0]              req,
  input  logic [chan_bits(NUM_CHANNELS)-1:0]   ptr,
  output logic [NUM_CHANNELS-1:0]              grant,
  output logic [chan_bits(NUM_CHANNELS)-1:0]   grant_idx,
  output logic                                 any_grant
);
  localparam int unsigned CH_BITS = chan_bits(NUM_CHANNELS);

  logic [CH_BITS-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sel       = '0;
    for (int unsigned off = 1; off <= NUM_CHANNELS; off++) begin
      sel = CH_BITS'((32'(ptr) + off) % NUM_CHANNELS);
      if (!any_grant && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: round-robin serialises channel reads/writes against
// an on-chip word array with a fixed grant-to-ready latency.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned LATENCY      = 2
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);
  localparam int unsigned CH_BITS = chan_bits(NUM_CHANNELS);
  localparam int unsigned DEPTH   = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  state_t                state, next_state;
  logic [CNT_BITS-1:0]   count;
  logic [CH_BITS-1:0]    ptr, lat_ch, gidx;
  op_t                   lat_op;
  logic [ADDR_BITS-1:0]  lat_addr;
  logic [DATA_BITS-1:0]  lat_data;
  logic [NUM_CHANNELS-1:0] wr_served, rd_served, wr_elig, rd_elig, grant;
  logic [NUM_CHANNELS-1:0] rd_ready, wr_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0] rd_data;
  logic [7:0]            grant_q;
  logic                  any_grant, grant_wr, grant_now, done, busy_c;

  assign wr_elig   = bus.ch_write_valid & ~wr_served;
  assign rd_elig   = bus.ch_read_valid  & ~rd_served;
  assign grant_wr  = |(grant & wr_elig);
  assign grant_now = (state == IDLE) && any_grant;
  assign done      = (state == BUSY) && (count == '0);

  rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_arb (
    .req       (wr_elig | rd_elig),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx),
    .any_grant (any_grant)
  );

  always_comb begin
    next_state = state;
    busy_c     = 1'b0;
    case (state)
      IDLE: if (any_grant) next_state = BUSY;
      BUSY: begin
        busy_c = 1'b1;
        if (count == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      ptr       <= CH_BITS'(NUM_CHANNELS - 1);
      lat_ch    <= '0;
      lat_op    <= OP_READ;
      lat_addr  <= '0;
      lat_data  <= '0;
      grant_q   <= '0;
      rd_ready  <= '0;
      wr_ready  <= '0;
      rd_data   <= '0;
      wr_served <= '0;
      rd_served <= '0;
    end else begin
      state    <= next_state;
      rd_ready <= '0;
      wr_ready <= '0;
      // Completion below re-sets the flag even if valid dropped mid-BUSY;
      // it then clears on the following edge.
      wr_served <= wr_served & bus.ch_write_valid;
      rd_served <= rd_served & bus.ch_read_valid;
      if (grant_now) begin
        lat_ch   <= gidx;
        lat_op   <= grant_wr ? OP_WRITE : OP_READ;
        lat_addr <= grant_wr ? bus.ch_write_address[32'(gidx)*ADDR_BITS +: ADDR_BITS]
                             : bus.ch_read_address[32'(gidx)*ADDR_BITS +: ADDR_BITS];
        lat_data <= bus.ch_write_data[32'(gidx)*DATA_BITS +: DATA_BITS];
        ptr      <= gidx;
        grant_q  <= 8'(gidx);
        count    <= CNT_BITS'(LATENCY - 1);
      end else if (state == BUSY) begin
        if (count == '0) begin
          if (lat_op == OP_WRITE) begin
            wr_ready[lat_ch]  <= 1'b1;
            wr_served[lat_ch] <= 1'b1;
          end else begin
            rd_data[32'(lat_ch)*DATA_BITS +: DATA_BITS] <= mem[lat_addr];
            rd_ready[lat_ch]  <= 1'b1;
            rd_served[lat_ch] <= 1'b1;
          end
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

  // Array is not reset; async reset forces IDLE, so an uncommitted write never lands.
  always_ff @(posedge clk) begin
    if (done && lat_op == OP_WRITE)
      mem[lat_addr] <= lat_data;
    else if (state == IDLE && !any_grant && bus.init_write_en)
      mem[bus.init_address] <= bus.init_data;
  end

  assign bus.ch_read_ready  = rd_ready;
  assign bus.ch_write_ready = wr_ready;
  assign bus.ch_read_data   = rd_data;
  assign bus.busy           = busy_c;
  assign bus.grant_channel  = grant_q;

endmodule
